// File: rtl/motion_code_vlc_decoder.sv
// MPEG-2 motion_code VLC decoder: table lookup on an 11-bit window,
// registered signed code and consumed-bit count.
module motion_code_vlc_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] buffer,
  input  logic        in_valid,
  output logic [4:0]  outshift,
  output logic [4:0]  mcode
);

  logic [8:0] c;
  logic [3:0] li;
  logic       zero;
  logic       short_r;
  logic       med_r;
  logic       long_r;

  assign c    = buffer[9:1];
  // c is 12..23 in the long range, so the low nibble of c-12 is exact
  assign li   = c[3:0] - 4'd12;
  assign zero = buffer[10];

  assign short_r = !zero && (c >= 9'd64);
  assign med_r   = !zero && (c <  9'd64) && (c >= 9'd24);
  assign long_r  = !zero && (c <  9'd24) && (c >= 9'd12);

  logic [4:0] val;
  logic [3:0] len;

  always_comb begin
    val = 5'd0;
    len = 4'd0;
    unique case (1'b1)
      short_r: begin
        case (c[8:6])
          3'd1: begin
            val = 5'd3;
            len = 4'd3;
          end
          3'd2, 3'd3: begin
            val = 5'd2;
            len = 4'd2;
          end
          default: begin
            val = 5'd1;
            len = 4'd1;
          end
        endcase
      end
      med_r: begin
        case (c[8:3])
          6'd3: begin
            val = 5'd7;
            len = 4'd6;
          end
          6'd4: begin
            val = 5'd6;
            len = 4'd6;
          end
          6'd5: begin
            val = 5'd5;
            len = 4'd6;
          end
          default: begin
            val = 5'd4;
            len = 4'd5;
          end
        endcase
      end
      long_r: begin
        case (li)
          4'd0: begin
            val = 5'd16;
            len = 4'd9;
          end
          4'd1: begin
            val = 5'd15;
            len = 4'd9;
          end
          4'd2: begin
            val = 5'd14;
            len = 4'd9;
          end
          4'd3: begin
            val = 5'd13;
            len = 4'd9;
          end
          4'd4: begin
            val = 5'd12;
            len = 4'd9;
          end
          4'd5: begin
            val = 5'd11;
            len = 4'd9;
          end
          4'd6, 4'd7: begin
            val = 5'd10;
            len = 4'd8;
          end
          4'd8, 4'd9: begin
            val = 5'd9;
            len = 4'd8;
          end
          default: begin
            val = 5'd8;
            len = 4'd8;
          end
        endcase
      end
      default: begin
        val = 5'd0;
        len = 4'd0;
      end
    endcase
  end

  logic [3:0] spos;
  logic       sgn;
  logic       hit;
  logic [4:0] mc_n;
  logic [4:0] os_n;

  // Sign bit sits right after the len code bits that follow buffer[10]
  assign spos = 4'd9 - len;
  assign sgn  = buffer[spos];
  assign hit  = |len;

  // Zero and invalid codes both consume just the first bit
  assign mc_n = !hit ? 5'd0 :
                sgn  ? (~val + 5'd1) : val;
  assign os_n = hit ? ({1'b0, len} + 5'd2) : 5'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      outshift <= 5'd0;
      mcode    <= 5'd0;
    end else if (in_valid) begin
      outshift <= os_n;
      mcode    <= mc_n;
    end
  end

endmodule

// File: tb/tb_motion_code_vlc_decoder.sv
// Scoreboard bench for motion_code_vlc_decoder: directed vectors,
// mid-stream reset, holds and a full 2048-value sweep.
module tb_motion_code_vlc_decoder;

  logic        clk;
  logic        rst;
  logic [10:0] buffer;
  logic        in_valid;
  logic [4:0]  outshift;
  logic [4:0]  mcode;

  motion_code_vlc_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .buffer   (buffer),
    .in_valid (in_valid),
    .outshift (outshift),
    .mcode    (mcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  string      name_q[$];
  logic       armed;
  int         tests;
  int         fails;
  logic [4:0] last_o;
  logic [4:0] last_m;

  // Codeword prefixes (leading 0 plus code bits, sign excluded)
  int         pval[16];
  int         plen[16];
  logic [9:0] pfx[16];

  initial begin
    pval = '{1, 2, 3, 4, 5, 6, 7, 8,
             9, 10, 11, 12, 13, 14, 15, 16};
    plen = '{2, 3, 4, 6, 7, 7, 7, 9,
             9, 9, 10, 10, 10, 10, 10, 10};
    pfx  = '{10'd1, 10'd1, 10'd1, 10'd3,
             10'd5, 10'd4, 10'd3, 10'd11,
             10'd10, 10'd9, 10'd17, 10'd16,
             10'd15, 10'd14, 10'd13, 10'd12};
  end

  function automatic logic [9:0] model(input logic [10:0] b);
    logic [10:0] top;
    logic [4:0]  m;
    logic [4:0]  o;
    m = 5'd0;
    o = 5'd1;
    if (!b[10]) begin
      for (int i = 0; i < 16; i++) begin
        top = b >> (11 - plen[i]);
        if (top == {1'b0, pfx[i]}) begin
          o = 5'(plen[i] + 1);
          m = 5'(pval[i]);
          if (b[10 - plen[i]]) m = 5'(-pval[i]);
        end
      end
    end
    return {o, m};
  endfunction

  task automatic step(input logic r, input logic v,
                      input logic [10:0] b,
                      input logic [4:0] eo,
                      input logic [4:0] em,
                      input string nm);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    buffer   = b;
    if (!r) begin
      last_o = 5'd0;
      last_m = 5'd0;
    end else if (v) begin
      last_o = eo;
      last_m = em;
    end
    exp_q.push_back({last_o, last_m});
    name_q.push_back(nm);
    armed = 1'b1;
  endtask

  task automatic dec(input logic [10:0] b,
                     input logic [4:0] eo,
                     input int em, input string nm);
    step(1'b1, 1'b1, b, eo, 5'(em), nm);
  endtask

  initial begin : monitor
    logic       due;
    logic [9:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      due   = armed;
      armed = 1'b0;
      @(negedge clk);
      if (due) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_underflow");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          tests++;
          if ({outshift, mcode} !== e) begin
            fails++;
            $display("FAIL %s: got os=%0d mc=%0d want os=%0d mc=%0d",
                     nm, outshift, $signed(mcode),
                     e[9:5], $signed(e[4:0]));
          end
        end
      end
    end
  end

  initial begin : driver
    logic [9:0] m;
    tests    = 0;
    fails    = 0;
    armed    = 1'b0;
    last_o   = 5'd0;
    last_m   = 5'd0;
    rst      = 1'b0;
    in_valid = 1'b1;
    buffer   = 11'b00011100000;

    step(1'b0, 1'b1, 11'b00011100000, 5'd0, 5'd0, "reset0");
    step(1'b0, 1'b1, 11'b00011100000, 5'd0, 5'd0, "reset1");
    step(1'b1, 1'b0, 11'b00011100000, 5'd0, 5'd0, "post_reset_hold");

    dec(11'b10110100101, 5'd1, 0, "zero");
    dec(11'b01000000000, 5'd3, 1, "plus1");
    dec(11'b01100000000, 5'd3, -1, "minus1");
    dec(11'b00011000000, 5'd5, -3, "minus3");
    dec(11'b00101010101, 5'd4, 2, "plus2");
    dec(11'b00001100000, 5'd7, 4, "plus4");
    dec(11'b00000111100, 5'd8, -7, "minus7");
    dec(11'b00001000111, 5'd8, 6, "plus6");
    dec(11'b00000011001, 5'd11, -16, "minus16");
    dec(11'b00000100100, 5'd10, 10, "plus10");
    dec(11'b00000011110, 5'd11, 13, "plus13");
    dec(11'b00000101100, 5'd10, 8, "plus8");
    dec(11'b00000100011, 5'd11, -11, "minus11");
    dec(11'b00000000000, 5'd1, 0, "invalid0");
    dec(11'b00000001011, 5'd1, 0, "invalid11");
    step(1'b1, 1'b0, 11'b01100000000, 5'd0, 5'd0, "hold_a");
    step(1'b1, 1'b0, 11'b00000011001, 5'd0, 5'd0, "hold_b");
    dec(11'b00000011001, 5'd11, -16, "minus16_again");
    step(1'b0, 1'b1, 11'b01000000000, 5'd0, 5'd0, "mid_reset");
    dec(11'b01100000000, 5'd3, -1, "after_reset");

    for (int i = 0; i < 2048; i++) begin
      m = model(11'(i));
      if (i % 97 == 13)
        step(1'b1, 1'b0, 11'(i), 5'd0, 5'd0, "sweep_hold");
      step(1'b1, 1'b1, 11'(i), m[9:5], m[4:0],
           $sformatf("sweep_%0d", i));
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
